// File: rtl/hazard_unit_pkg.sv
// Shared constants for the hazard unit: instruction field positions, opcodes,
// register-index width and the 2-bit FSM state encoding.
package hazard_unit_pkg;

  localparam int INST_W  = 32;
  localparam int REG_W   = 5;
  localparam int OP_LSB  = 0;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_J    = 7'b1101111;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_MEM_WAIT   = 2'd2,
    ST_FLUSH      = 2'd3
  } state_t;

endpackage

// File: rtl/hazard_unit_detect.sv
// Combinational load-use detector: decodes which source registers the
// instruction in ID reads and compares them against the load destination in EX.
module hazard_detect
  import hazard_unit_pkg::*;
(
  input  logic [INST_W-1:0] inst,
  input  logic              mem_read,
  input  logic [REG_W-1:0]  rd,
  output logic              load_use
);

  logic [6:0]       opcode;
  logic [REG_W-1:0] rs1;
  logic [REG_W-1:0] rs2;
  logic             use_rs1;
  logic             use_rs2;
  logic             unused_fields;

  assign opcode        = inst[OP_LSB +: 7];
  assign rs1           = inst[RS1_LSB +: REG_W];
  assign rs2           = inst[RS2_LSB +: REG_W];
  // funct/rd/immediate bits play no part in hazard detection
  assign unused_fields = ^{inst[31:25], inst[14:7]};

  // Source-use decode: J and unknown opcodes read no registers
  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (opcode)
      OP_R, OP_B, OP_S: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_ADDI, OP_LW: use_rs1 = 1'b1;
      default: ;
    endcase
  end

  // x0 is never a real dependency, so rd==0 never triggers a stall
  assign load_use = mem_read && (rd != '0) &&
                    ((use_rs1 && (rd == rs1)) || (use_rs2 && (rd == rs2)));

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: FSM that resolves taken branches (flush), data-memory
// wait (whole-pipe hold) and load-use hazards (one bubble), in that priority.
// Optional feature macro: HAZARD_PERF_EN adds 32-bit stall_cnt / flush_cnt.
module hazard_unit
  import hazard_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [INST_W-1:0] if_id_inst,
  input  logic              id_ex_mem_read,
  input  logic [REG_W-1:0]  id_ex_rd,
  input  logic              branch_taken,
  input  logic              mem_busy,
  output logic              stall,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              pipe_hold
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  state_t state_q;
  state_t state_d;
  logic   load_use;
  logic   stall_raw;
  logic   pc_write_raw;
  logic   if_id_write_raw;
  logic   flush_raw;
  logic   pipe_hold_raw;

  hazard_detect u_detect (
    .inst     (if_id_inst),
    .mem_read (id_ex_mem_read),
    .rd       (id_ex_rd),
    .load_use (load_use)
  );

  // State register; reset abandons any pending bubble, flush or wait
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  // Next state and raw controls; load-use is only honoured from RUN or on
  // leaving MEM_WAIT, which limits each hazard to exactly one bubble
  always_comb begin
    state_d         = state_q;
    stall_raw       = 1'b0;
    pc_write_raw    = 1'b1;
    if_id_write_raw = 1'b1;
    flush_raw       = 1'b0;
    pipe_hold_raw   = 1'b0;
    if (branch_taken) begin
      flush_raw = 1'b1;
      state_d   = ST_FLUSH;
    end else if (mem_busy) begin
      pc_write_raw    = 1'b0;
      if_id_write_raw = 1'b0;
      pipe_hold_raw   = 1'b1;
      state_d         = ST_MEM_WAIT;
    end else begin
      case (state_q)
        ST_RUN, ST_MEM_WAIT: begin
          if (load_use) begin
            stall_raw       = 1'b1;
            pc_write_raw    = 1'b0;
            if_id_write_raw = 1'b0;
            state_d         = ST_LOAD_STALL;
          end else begin
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  // Reset forces the idle control pattern at the ports without waiting for a clock
  always_comb begin
    stall       = stall_raw       & ~rst;
    pc_write    = pc_write_raw    | rst;
    if_id_write = if_id_write_raw | rst;
    if_id_flush = flush_raw       & ~rst;
    id_ex_flush = flush_raw       & ~rst;
    pipe_hold   = pipe_hold_raw   & ~rst;
  end

`ifdef HAZARD_PERF_EN
  // Event counters: one count per bubble and per taken-branch cycle, wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + {31'd0, stall_raw};
      flush_cnt <= flush_cnt + {31'd0, flush_raw};
    end
  end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus randomized
// traffic against a rule-level reference model.
module tb_hazard_unit;
  import hazard_unit_pkg::*;

  logic              clk;
  logic              rst;
  logic [INST_W-1:0] if_id_inst;
  logic              id_ex_mem_read;
  logic [REG_W-1:0]  id_ex_rd;
  logic              branch_taken;
  logic              mem_busy;
  logic              stall, pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold;
`ifdef HAZARD_PERF_EN
  logic [31:0]       stall_cnt, flush_cnt;
  logic [31:0]       m_stall_cnt, m_flush_cnt;
`endif

  hazard_unit dut (
    .clk            (clk),
    .rst            (rst),
    .if_id_inst     (if_id_inst),
    .id_ex_mem_read (id_ex_mem_read),
    .id_ex_rd       (id_ex_rd),
    .branch_taken   (branch_taken),
    .mem_busy       (mem_busy),
    .stall          (stall),
    .pc_write       (pc_write),
    .if_id_write    (if_id_write),
    .if_id_flush    (if_id_flush),
    .id_ex_flush    (id_ex_flush),
    .pipe_hold      (pipe_hold)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {stall, pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold}
  logic [5:0] outs;
  assign outs = {stall, pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold};

  localparam logic [5:0] O_RUN   = 6'b011000;
  localparam logic [5:0] O_STALL = 6'b100000;
  localparam logic [5:0] O_BR    = 6'b011110;
  localparam logic [5:0] O_HOLD  = 6'b000001;

  typedef enum {EV_NONE, EV_BRANCH, EV_BUBBLE, EV_HOLD} evt_e;

  int   n_checks = 0;
  int   n_fail   = 0;
  evt_e last_evt;

  function automatic logic [31:0] mk_inst(input logic [6:0] op, input logic [4:0] r1,
                                          input logic [4:0] r2);
    return {7'd0, r2, r1, 3'd0, 5'd9, op};
  endfunction

  // Reference: what the previous cycle did decides whether a match may stall
  function automatic void model(input logic [31:0] inst, input logic mr, input logic [4:0] rd,
                                input logic br, input logic mb, input evt_e prev,
                                output logic [5:0] o, output evt_e ev);
    logic [6:0] op;
    logic       reads1, reads2, haz;
    op     = inst[6:0];
    reads1 = op inside {OP_R, OP_B, OP_S, OP_ADDI, OP_LW};
    reads2 = op inside {OP_R, OP_B, OP_S};
    haz    = mr && (rd != 5'd0) &&
             ((reads1 && rd == inst[19:15]) || (reads2 && rd == inst[24:20]));
    if (br)                                             begin o = O_BR;    ev = EV_BRANCH; end
    else if (mb)                                        begin o = O_HOLD;  ev = EV_HOLD;   end
    else if (haz && (prev == EV_NONE || prev == EV_HOLD)) begin o = O_STALL; ev = EV_BUBBLE; end
    else                                                begin o = O_RUN;   ev = EV_NONE;   end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] inst, input logic mr, input logic [4:0] rd,
                       input logic br, input logic mb);
    if_id_inst     = inst;
    id_ex_mem_read = mr;
    id_ex_rd       = rd;
    branch_taken   = br;
    mem_busy       = mb;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(mk_inst(OP_R, 5'd5, 5'd7), 1'b1, 5'd5, 1'b1, 1'b1);
    #2;
    n_checks++;
    if (outs !== O_RUN) begin n_fail++; $display("FAIL reset_outs got %b want %b", outs, O_RUN); end
    tick();
    n_checks++;
    if (outs !== O_RUN) begin n_fail++; $display("FAIL reset_held got %b want %b", outs, O_RUN); end
`ifdef HAZARD_PERF_EN
    n_checks++;
    if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      n_fail++; $display("FAIL reset_cnt got %0d/%0d want 0/0", stall_cnt, flush_cnt);
    end
`endif
    drive(32'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_load_use();
    drive(mk_inst(OP_R, 5'd5, 5'd7), 1'b1, 5'd5, 1'b0, 1'b0);
    @(negedge clk);
    n_checks++;
    if (outs !== O_STALL) begin n_fail++; $display("FAIL lu_bubble got %b want %b", outs, O_STALL); end
    tick();
    @(negedge clk);
    n_checks++;
    if (outs !== O_RUN) begin n_fail++; $display("FAIL lu_after got %b want %b", outs, O_RUN); end
    drive(32'd0, 1'b0, 5'd0, 1'b0, 1'b0);
`ifdef HAZARD_PERF_EN
    n_checks++;
    if (stall_cnt !== 32'd1) begin n_fail++; $display("FAIL lu_cnt got %0d want 1", stall_cnt); end
`endif
    tick();
  endtask

  task automatic test_x0_unused();
    logic [31:0] insts [5];
    logic [4:0]  rds   [5];
    logic        mrs   [5];
    insts = '{mk_inst(OP_R, 5'd0, 5'd0), mk_inst(OP_J, 5'd5, 5'd5),
              mk_inst(7'h7f, 5'd5, 5'd5), mk_inst(OP_ADDI, 5'd3, 5'd5),
              mk_inst(OP_R, 5'd5, 5'd5)};
    rds   = '{5'd0, 5'd5, 5'd5, 5'd5, 5'd5};
    mrs   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      drive(insts[i], mrs[i], rds[i], 1'b0, 1'b0);
      @(negedge clk);
      n_checks++;
      if (outs !== O_RUN) begin n_fail++; $display("FAIL nouse_%0d got %b want %b", i, outs, O_RUN); end
      tick();
    end
    // store reads rs2: a match there must stall
    drive(mk_inst(OP_S, 5'd3, 5'd5), 1'b1, 5'd5, 1'b0, 1'b0);
    @(negedge clk);
    n_checks++;
    if (outs !== O_STALL) begin n_fail++; $display("FAIL s_rs2 got %b want %b", outs, O_STALL); end
    tick();
    drive(32'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_branch();
    drive(mk_inst(OP_R, 5'd5, 5'd7), 1'b1, 5'd5, 1'b1, 1'b0);
    @(negedge clk);
    n_checks++;
    if (outs !== O_BR) begin n_fail++; $display("FAIL br_flush got %b want %b", outs, O_BR); end
    tick();
    branch_taken = 1'b0;
    @(negedge clk);
    n_checks++;
    if (outs !== O_RUN) begin n_fail++; $display("FAIL br_flushstate got %b want %b", outs, O_RUN); end
`ifdef HAZARD_PERF_EN
    n_checks++;
    if (flush_cnt !== 32'd1) begin n_fail++; $display("FAIL br_cnt got %0d want 1", flush_cnt); end
`endif
    drive(32'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_mem_wait();
    for (int i = 0; i < 3; i++) begin
      drive(32'd0, 1'b0, 5'd0, 1'b0, 1'b1);
      @(negedge clk);
      n_checks++;
      if (outs !== O_HOLD) begin n_fail++; $display("FAIL mw_hold%0d got %b want %b", i, outs, O_HOLD); end
      tick();
    end
    mem_busy = 1'b0;
    @(negedge clk);
    n_checks++;
    if (outs !== O_RUN) begin n_fail++; $display("FAIL mw_release got %b want %b", outs, O_RUN); end
    tick();
    // a hazard seen while leaving MEM_WAIT stalls in that same cycle
    mem_busy = 1'b1;
    tick();
    drive(mk_inst(OP_LW, 5'd4, 5'd0), 1'b1, 5'd4, 1'b0, 1'b0);
    @(negedge clk);
    n_checks++;
    if (outs !== O_STALL) begin n_fail++; $display("FAIL mw_hazard got %b want %b", outs, O_STALL); end
    tick();
    drive(32'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_async_reset();
    drive(mk_inst(OP_B, 5'd1, 5'd6), 1'b1, 5'd6, 1'b0, 1'b0);
    @(negedge clk);
    n_checks++;
    if (outs !== O_STALL) begin n_fail++; $display("FAIL ar_pre got %b want %b", outs, O_STALL); end
    tick();
    #1;
    rst          = 1'b1;
    branch_taken = 1'b1;
    #1;
    n_checks++;
    if (outs !== O_RUN) begin n_fail++; $display("FAIL ar_outs got %b want %b", outs, O_RUN); end
`ifdef HAZARD_PERF_EN
    n_checks++;
    if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      n_fail++; $display("FAIL ar_cnt got %0d/%0d want 0/0", stall_cnt, flush_cnt);
    end
`endif
    drive(32'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (outs !== O_RUN) begin n_fail++; $display("FAIL ar_first got %b want %b", outs, O_RUN); end
    tick();
`ifdef HAZARD_PERF_EN
    n_checks++;
    if (stall_cnt !== 32'd0) begin n_fail++; $display("FAIL ar_nobubble got %0d want 0", stall_cnt); end
`endif
  endtask

  task automatic test_random();
    logic [6:0]  ops [7];
    logic [31:0] inst;
    logic [5:0]  exp_o;
    evt_e        ev;
    ops = '{OP_R, OP_B, OP_ADDI, OP_LW, OP_S, OP_J, 7'h7f};
    last_evt = EV_NONE;
`ifdef HAZARD_PERF_EN
    m_stall_cnt = 32'd0;
    m_flush_cnt = 32'd0;
`endif
    for (int i = 0; i < 400; i++) begin
      inst = mk_inst(ops[$urandom_range(0, 6)], 5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)));
      drive(inst, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 5)),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0));
      @(negedge clk);
      model(inst, id_ex_mem_read, id_ex_rd, branch_taken, mem_busy, last_evt, exp_o, ev);
      n_checks++;
      if (outs !== exp_o) begin n_fail++; $display("FAIL rand_%0d got %b want %b", i, outs, exp_o); end
      tick();
      last_evt = ev;
`ifdef HAZARD_PERF_EN
      if (ev == EV_BUBBLE) m_stall_cnt++;
      if (ev == EV_BRANCH) m_flush_cnt++;
      n_checks++;
      if (stall_cnt !== m_stall_cnt || flush_cnt !== m_flush_cnt) begin
        n_fail++;
        $display("FAIL rand_cnt_%0d got %0d/%0d want %0d/%0d", i, stall_cnt, flush_cnt,
                 m_stall_cnt, m_flush_cnt);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_x0_unused();
    test_branch();
    test_mem_wait();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
